// File: rtl/dmem_lsu_if.sv
// CPU-side request/response and RAM-side word bus of the load/store unit.
// master = CPU + RAM environment, slave = the LSU itself.
interface dmem_lsu_if #(
    parameter int ADDR_W = 12
);
    logic              req;
    logic              we;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ready;
    logic              fault;
    logic              busy;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic [31:0]       mem_rdata;

    modport master (
        output req, we, funct3, addr, wdata, mem_rdata,
        input  rdata, ready, fault, busy,
        input  mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  req, we, funct3, addr, wdata, mem_rdata,
        output rdata, ready, fault, busy,
        output mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit for a single-port synchronous-read RAM.
// Sub-word stores are done as read-modify-write of the whole word.
module dmem_lsu #(
    parameter int ADDR_W = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    dmem_lsu_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOAD_CAP,
        RMW_RD,
        RMW_MERGE,
        WRITE,
        DONE
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        f3_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [31:0]       mem_wdata_q;
    logic              fault_q;

    logic              fault_d;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_d;
    logic [31:0]       merge_d;

    // Legality is judged on the live request so it can be latched at accept.
    always_comb begin
        fault_d = 1'b0;
        unique case (bus.funct3)
            3'b000:         fault_d = 1'b0;
            3'b001:         fault_d = bus.addr[0];
            3'b010:         fault_d = |bus.addr[1:0];
            3'b100, 3'b101: fault_d = bus.we;
            default:        fault_d = 1'b1;
        endcase
    end

    always_comb begin
        byte_sel = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_sel = addr_q[1] ? bus.mem_rdata[31:16]
                             : bus.mem_rdata[15:0];
        load_d   = bus.mem_rdata;
        unique case (f3_q)
            3'b000:  load_d = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_d = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_d = {24'h0, byte_sel};
            3'b101:  load_d = {16'h0, half_sel};
            default: load_d = bus.mem_rdata;
        endcase
    end

    always_comb begin
        merge_d = bus.mem_rdata;
        if (f3_q == 3'b000) begin
            merge_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else if (addr_q[1]) begin
            merge_d[31:16] = wdata_q[15:0];
        end else begin
            merge_d[15:0] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            f3_q        <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            mem_wdata_q <= '0;
            fault_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        addr_q      <= bus.addr;
                        f3_q        <= bus.funct3;
                        wdata_q     <= bus.wdata;
                        mem_wdata_q <= bus.wdata;
                        fault_q     <= fault_d;
                        if (fault_d) begin
                            state_q <= DONE;
                        end else if (!bus.we) begin
                            state_q <= LOAD;
                        end else if (bus.funct3 == 3'b010) begin
                            state_q <= WRITE;
                        end else begin
                            state_q <= RMW_RD;
                        end
                    end
                end
                LOAD:      state_q <= LOAD_CAP;
                LOAD_CAP: begin
                    rdata_q <= load_d;
                    state_q <= DONE;
                end
                RMW_RD:    state_q <= RMW_MERGE;
                RMW_MERGE: begin
                    mem_wdata_q <= merge_d;
                    state_q     <= WRITE;
                end
                WRITE:     state_q <= DONE;
                DONE:      state_q <= IDLE;
                default:   state_q <= IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so reset kills them at once.
    assign bus.ready     = (state_q == DONE);
    assign bus.mem_we    = (state_q == WRITE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rdata     = rdata_q;
    assign bus.fault     = fault_q;
    assign bus.mem_addr  = addr_q[ADDR_W-1:2];
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu against a byte-array reference model.
// Drives the CPU side and models the synchronous-read RAM.
module tb_dmem_lsu;

    localparam int AW = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_lsu_if #(.ADDR_W(AW)) bus ();

    dmem_lsu #(.ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] ram [0:1023];
    logic [7:0]  refb [0:4095];
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          wes;
        int          start;
        logic [9:0]  widx;
        logic [31:0] word;
    } exp_t;

    exp_t        sbq[$];
    int          passed = 0;
    int          total = 0;
    logic [31:0] model_rd = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] refword(input int i);
        return {refb[4*i+3], refb[4*i+2], refb[4*i+1], refb[4*i]};
    endfunction

    // Monitor: counts strobes per transaction and checks at each ready.
    int bcnt = 0;
    int wcnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            bcnt = 0;
            wcnt = 0;
        end else begin
            if (bus.busy) bcnt++;
            if (bus.mem_we) wcnt++;
            if (bus.ready) begin
                if (sbq.size() == 0) begin
                    total++;
                    $display("FAIL spurious_ready: got ready expected none");
                end else begin
                    e = sbq.pop_front();
                    chk({e.name, ".lat"}, 32'(cyc - e.start), 32'(e.lat));
                    chk({e.name, ".rdata"}, bus.rdata, e.rdata);
                    chk({e.name, ".fault"}, 32'(bus.fault), 32'(e.fault));
                    chk({e.name, ".we_pulses"}, 32'(wcnt), 32'(e.wes));
                    chk({e.name, ".busy_cycles"}, 32'(bcnt), 32'(e.lat));
                    chk({e.name, ".mem_addr"}, 32'(bus.mem_addr), 32'(e.widx));
                    chk({e.name, ".ram_word"}, ram[e.widx], e.word);
                end
                bcnt = 0;
                wcnt = 0;
            end
        end
    end

    // Caller is positioned at a negedge in IDLE; accept is the next posedge.
    task automatic issue(input string nm, input logic w, input logic [2:0] f3,
                         input logic [11:0] a, input logic [31:0] wd,
                         input bit hold);
        exp_t        e;
        int          size;
        bit          legal;
        logic [31:0] v;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = w ? (f3 inside {3'd0, 3'd1, 3'd2})
                  : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        e.name  = nm;
        e.fault = !legal || (int'(a) % size != 0);
        e.wes   = 0;
        if (e.fault) begin
            e.lat = 1;
        end else if (!w) begin
            v = '0;
            for (int k = 0; k < size; k++)
                v |= 32'(refb[int'(a) + k]) << (8 * k);
            if (!f3[2] && size < 4 && v[8*size-1])
                v |= 32'hFFFF_FFFF << (8 * size);
            model_rd = v;
            e.lat = 3;
        end else begin
            for (int k = 0; k < size; k++)
                refb[int'(a) + k] = wd[8*k +: 8];
            e.lat = (size == 4) ? 2 : 4;
            e.wes = 1;
        end
        e.rdata = model_rd;
        e.widx  = a[11:2];
        e.word  = refword(int'(a[11:2]));
        e.start = cyc;
        sbq.push_back(e);
        bus.req    = 1'b1;
        bus.we     = w;
        bus.funct3 = f3;
        bus.addr   = a;
        bus.wdata  = wd;
        @(posedge clk);
        #1;
        if (!hold) bus.req = 1'b0;
    endtask

    task automatic wait_done(input bit hold);
        int n = 0;
        while (sbq.size() != 0 && n < 30) begin
            @(negedge clk);
            #1;
            n++;
            if (hold) bus.addr = 12'($urandom);
        end
        if (sbq.size() != 0) begin
            total++;
            $display("FAIL ready_timeout: got no ready expected ready");
            sbq.delete();
        end
        @(negedge clk);
        chk("busy_after_done", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        logic        w;
        logic [2:0]  f3;
        logic [11:0] a;
        logic [31:0] orig;

        for (int i = 0; i < 1024; i++) ram[i] = '0;
        for (int i = 0; i < 4096; i++) refb[i] = '0;
        ram[5] = 32'h8BAD_F01D;
        {refb[23], refb[22], refb[21], refb[20]} = 32'h8BAD_F01D;
        bus.req    = 1'b0;
        bus.we     = 1'b0;
        bus.funct3 = '0;
        bus.addr   = '0;
        bus.wdata  = '0;

        #3;
        chk("rst.rdata", bus.rdata, 32'd0);
        chk("rst.ready", 32'(bus.ready), 32'd0);
        chk("rst.fault", 32'(bus.fault), 32'd0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst.mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst.mem_wdata", bus.mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue("lw_014", 1'b0, 3'b010, 12'h014, 32'h0, 1'b0);  wait_done(1'b0);
        issue("lb_017", 1'b0, 3'b000, 12'h017, 32'h0, 1'b0);  wait_done(1'b0);
        issue("lbu_017", 1'b0, 3'b100, 12'h017, 32'h0, 1'b0); wait_done(1'b0);
        issue("lh_014", 1'b0, 3'b001, 12'h014, 32'h0, 1'b0);  wait_done(1'b0);
        issue("lhu_016", 1'b0, 3'b101, 12'h016, 32'h0, 1'b0); wait_done(1'b0);
        issue("lb_015", 1'b0, 3'b000, 12'h015, 32'h0, 1'b0);  wait_done(1'b0);
        issue("sb_015", 1'b1, 3'b000, 12'h015, 32'hDEAD_BEAA, 1'b0);
        wait_done(1'b0);
        issue("sh_016", 1'b1, 3'b001, 12'h016, 32'h0000_1234, 1'b0);
        wait_done(1'b0);
        issue("sw_014", 1'b1, 3'b010, 12'h014, 32'h0BAD_F00D, 1'b0);
        wait_done(1'b0);
        issue("f_lw_016", 1'b0, 3'b010, 12'h016, 32'h0, 1'b0); wait_done(1'b0);
        issue("f_sh_013", 1'b1, 3'b001, 12'h013, 32'h5555, 1'b0);
        wait_done(1'b0);
        issue("f_ld_011", 1'b0, 3'b011, 12'h014, 32'h0, 1'b0); wait_done(1'b0);
        issue("f_st_100", 1'b1, 3'b100, 12'h014, 32'h7777, 1'b0);
        wait_done(1'b0);
        issue("lw_after_f", 1'b0, 3'b010, 12'h014, 32'h0, 1'b0);
        wait_done(1'b0);

        ram[6] = 32'h1357_9BDF;
        {refb[27], refb[26], refb[25], refb[24]} = 32'h1357_9BDF;
        issue("held_lw_014", 1'b0, 3'b010, 12'h014, 32'h0, 1'b1);
        wait_done(1'b1);
        issue("held_next_018", 1'b0, 3'b010, 12'h018, 32'h0, 1'b0);
        wait_done(1'b0);

        // Reset while the SB merge is in flight: nothing may be written.
        orig       = refword(5);
        bus.req    = 1'b1;
        bus.we     = 1'b1;
        bus.funct3 = 3'b000;
        bus.addr   = 12'h014;
        bus.wdata  = 32'hCAFE_BABE;
        @(posedge clk);
        #1 bus.req = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.ready", 32'(bus.ready), 32'd0);
        chk("arst.busy", 32'(bus.busy), 32'd0);
        chk("arst.mem_we", 32'(bus.mem_we), 32'd0);
        chk("arst.rdata", bus.rdata, 32'd0);
        chk("arst.fault", 32'(bus.fault), 32'd0);
        chk("arst.mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("arst.mem_wdata", bus.mem_wdata, 32'd0);
        repeat (3) @(posedge clk);
        #1 chk("arst.word5", ram[5], orig);
        @(negedge clk);
        rst_n = 1'b1;
        model_rd = '0;
        @(negedge clk);
        chk("arst.busy_after", 32'(bus.busy), 32'd0);
        issue("lw_after_rst", 1'b0, 3'b010, 12'h014, 32'h0, 1'b0);
        wait_done(1'b0);

        for (int i = 0; i < 60; i++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 12'($urandom_range(0, 63));
            issue("rand", w, f3, a, $urandom, 1'b0);
            wait_done(1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
